// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the UART transmitter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_byte;
    logic [NREQ-1:0]   ack;
    logic              transmit;
    logic [7:0]        tx_byte;
    logic              is_transmitting;
    logic              busy;
    logic              timeout_err;

    modport master (
        output req,
        output req_byte,
        output is_transmitting,
        input  ack,
        input  transmit,
        input  tx_byte,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  req_byte,
        input  is_transmitting,
        output ack,
        output transmit,
        output tx_byte,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters: round-robin by default,
// fixed lowest-index priority when UART_ARB_FIXED_PRIO_EN is defined.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [NREQ-1:0] ack_q;
    logic            transmit_q;
    logic [7:0]      tx_byte_q;
    logic            timeout_err_q;

    logic            grant_valid_d;
    logic [PW-1:0]   grant_idx_d;
    logic [7:0]      cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Scanning downwards leaves the lowest requesting index as the winner.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                grant_valid_d = 1'b1;
                grant_idx_d   = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] cand_idx;

    // Walk the search order backwards so the candidate closest to the pointer wins.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
        cand_idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_idx = PW'((int'(ptr_q) + k) % NREQ);
            if (bus.req[cand_idx]) begin
                grant_valid_d = 1'b1;
                grant_idx_d   = cand_idx;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            ack_q         <= '0;
            transmit_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            timeout_err_q <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr_q         <= '0;
`endif
        end else begin
            transmit_q <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        state_q    <= WAIT_BUSY;
                        transmit_q <= 1'b1;
                        ack_q      <= NREQ'(1) << grant_idx_d;
                        tx_byte_q  <= bus.req_byte[{grant_idx_d, 3'b000} +: 8];
                        cnt_q      <= 8'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
                        ptr_q      <= (grant_idx_d == PW'(NREQ - 1)) ? '0 : grant_idx_d + 1'b1;
`endif
                    end
                end
                // A busy flag seen on the deadline cycle still counts as a start.
                WAIT_BUSY: begin
                    if (bus.is_transmitting) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == 8'(BUSY_TIMEOUT)) begin
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.is_transmitting) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.transmit    = transmit_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a reference model predicts every grant into a
// scoreboard queue and a negedge monitor compares what the arbiter presents.
module tb_uart_tx_arbiter;
    localparam int NREQ         = 4;
    localparam int BUSY_TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         atEdge;
        int         idx;
        logic [7:0] data;
    } grant_t;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [7:0]      data;
    } seen_t;

    grant_t expQ[$];
    seen_t  seenLog[$];

    int assertCount = 0;
    int failCount   = 0;
    int edgeNum     = 0;
    int grantsSeen  = 0;

    // Reference model: arbiter phase 0 = free, 1 = waiting for UART start, 2 = UART sending
    int         mPhase = 0;
    int         mPtr   = 0;
    int         mWait  = 0;
    logic       mErr   = 1'b0;
    logic [7:0] mByte  = 8'h00;

    logic holdReq   = 1'b0;
    logic randomReq = 1'b0;
    logic uartEn    = 1'b0;
    int   uDelayMin = 1;
    int   uDelayMax = 1;
    int   uLenMin   = 1;
    int   uLenMax   = 1;
    int   uState    = 0;
    int   uCount    = 0;

    grant_t          monE;
    logic [NREQ-1:0] monAck;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mPtr   = 0;
        mWait  = 0;
        mErr   = 1'b0;
        mByte  = 8'h00;
        expQ.delete();
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] r);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (r[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    task automatic modelStep();
        int w;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (mPhase == 0) begin
            if (bus.req != '0) begin
                w = pickWinner(bus.req);
                mByte = bus.req_byte[8*w +: 8];
                expQ.push_back('{atEdge: edgeNum, idx: w, data: mByte});
                mPtr   = (w + 1) % NREQ;
                mWait  = 0;
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            if (bus.is_transmitting) begin
                mPhase = 2;
            end else begin
                mWait++;
                if (mWait >= BUSY_TIMEOUT) begin
                    mErr   = 1'b1;
                    mPhase = 0;
                end
            end
        end else begin
            if (!bus.is_transmitting) mPhase = 0;
        end
    endtask

    // Requesters hold until acked (unless told to keep holding); the UART goes busy after a random delay.
    task automatic applyStimulus();
        logic [NREQ-1:0]   r;
        logic [8*NREQ-1:0] rb;
        r  = bus.req;
        rb = bus.req_byte;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i] && !holdReq) begin
                r[i] = 1'b0;
            end else if (randomReq && !r[i] && ($urandom_range(0, 3) == 0)) begin
                r[i] = 1'b1;
                rb[8*i +: 8] = 8'($urandom);
            end
        end
        bus.req_byte = rb;
        bus.req      = r;
        if (uartEn && bus.transmit) begin
            bus.is_transmitting = 1'b0;
            uCount = int'($urandom_range(uDelayMax, uDelayMin));
            uState = 1;
        end else if (uState == 1) begin
            uCount--;
            if (uCount <= 0) begin
                bus.is_transmitting = 1'b1;
                uCount = int'($urandom_range(uLenMax, uLenMin));
                uState = 2;
            end
        end else if (uState == 2) begin
            uCount--;
            if (uCount <= 0) begin
                bus.is_transmitting = 1'b0;
                uState = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edgeNum++;
        modelStep();
        #1;
        applyStimulus();
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        checkOutput({name, "_idle_bound"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic waitGrants(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (grantsSeen < target && n < limit) begin
            tick();
            n++;
        end
        checkOutput({name, "_grant_bound"}, 32'(grantsSeen >= target), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever the arbiter strobes, and tracks busy/error/byte every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.transmit || (bus.ack != '0)) begin
                grantsSeen++;
                seenLog.push_back('{ack: bus.ack, data: bus.tx_byte});
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_grant", 32'({bus.ack, bus.transmit}), 32'd0);
                end else begin
                    monE   = expQ.pop_front();
                    monAck = '0;
                    monAck[monE.idx] = 1'b1;
                    checkOutput("grant_edge", 32'(edgeNum), 32'(monE.atEdge));
                    checkOutput("grant_ack", 32'(bus.ack), 32'(monAck));
                    checkOutput("grant_transmit", 32'(bus.transmit), 32'd1);
                    checkOutput("grant_tx_byte", 32'(bus.tx_byte), 32'(monE.data));
                end
            end else if (expQ.size() != 0) begin
                monE   = expQ.pop_front();
                monAck = '0;
                monAck[monE.idx] = 1'b1;
                checkOutput("missing_grant", 32'({bus.ack, bus.transmit}), 32'({monAck, 1'b1}));
            end
            checkOutput("busy", 32'(bus.busy), 32'(mPhase != 0));
            checkOutput("timeout_err", 32'(bus.timeout_err), 32'(mErr));
            checkOutput("tx_byte_hold", 32'(bus.tx_byte), 32'(mByte));
        end
    end

    initial begin
        int g0;
`ifdef UART_ARB_FIXED_PRIO_EN
        int rrOrder[5] = '{0, 0, 0, 0, 0};
`else
        int rrOrder[5] = '{0, 1, 2, 3, 0};
`endif
        logic [NREQ-1:0] ea;

        bus.req             = '0;
        bus.req_byte        = '0;
        bus.is_transmitting = 1'b0;
        rst_n               = 1'b0;
        #1;
        checkOutput("reset_transmit", 32'(bus.transmit), 32'd0);
        checkOutput("reset_ack", 32'(bus.ack), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_tx_byte", 32'(bus.tx_byte), 32'd0);
        checkOutput("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] all four requesters held");
        seenLog.delete();
        holdReq   = 1'b1;
        uartEn    = 1'b1;
        uDelayMin = 1;
        uDelayMax = 1;
        uLenMin   = 3;
        uLenMax   = 3;
        bus.req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'b1111;
        g0 = grantsSeen;
        waitGrants(g0 + 5, 300, "rr");
        bus.req = '0;
        waitIdle(100, "rr");
        for (int j = 0; j < 5; j++) begin
            if (j < seenLog.size()) begin
                ea = '0;
                ea[rrOrder[j]] = 1'b1;
                checkOutput($sformatf("order_ack_%0d", j), 32'(seenLog[j].ack), 32'(ea));
                checkOutput($sformatf("order_byte_%0d", j), 32'(seenLog[j].data), 32'(8'h10 + rrOrder[j]));
            end
        end

`ifdef UART_ARB_FIXED_PRIO_EN
        $display("[TB] fixed priority with req 0110");
        tick();
        seenLog.delete();
        bus.req_byte = {8'h00, 8'h22, 8'h21, 8'h00};
        bus.req      = 4'b0110;
        g0 = grantsSeen;
        waitGrants(g0 + 4, 300, "prio");
        bus.req = '0;
        waitIdle(100, "prio");
        for (int j = 0; j < seenLog.size(); j++) begin
            checkOutput($sformatf("prio_ack_%0d", j), 32'(seenLog[j].ack), 32'(4'b0010));
        end
`endif

        $display("[TB] single request on requester 2");
        tick();
        holdReq   = 1'b0;
        uDelayMin = 2;
        uDelayMax = 2;
        uLenMin   = 10;
        uLenMax   = 10;
        seenLog.delete();
        bus.req_byte[23:16] = 8'hA5;
        bus.req             = 4'b0100;
        g0 = grantsSeen;
        waitGrants(g0 + 1, 20, "single");
        waitIdle(100, "single");
        repeat (3) tick();
        checkOutput("single_grant_count", 32'(grantsSeen - g0), 32'd1);
        if (seenLog.size() > 0) begin
            checkOutput("single_ack", 32'(seenLog[0].ack), 32'(4'b0100));
        end
        checkOutput("single_tx_byte", 32'(bus.tx_byte), 32'(8'hA5));

        $display("[TB] UART never goes busy");
        uartEn              = 1'b0;
        uState              = 0;
        bus.is_transmitting = 1'b0;
        holdReq             = 1'b1;
        bus.req_byte[15:8]  = 8'h5A;
        bus.req             = 4'b0010;
        tick();
        checkOutput("to_first_transmit", 32'(bus.transmit), 32'd1);
        repeat (BUSY_TIMEOUT - 1) tick();
        checkOutput("to_err_before", 32'(bus.timeout_err), 32'd0);
        checkOutput("to_busy_before", 32'(bus.busy), 32'd1);
        tick();
        checkOutput("to_err_set", 32'(bus.timeout_err), 32'd1);
        checkOutput("to_busy_after", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("to_regrant_ack", 32'(bus.ack), 32'(4'b0010));
        checkOutput("to_regrant_transmit", 32'(bus.transmit), 32'd1);
        bus.req = '0;
        holdReq = 1'b0;
        waitIdle(50, "to");
        checkOutput("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        $display("[TB] randomized traffic");
        uartEn    = 1'b1;
        randomReq = 1'b1;
        uDelayMin = 1;
        uDelayMax = 18;
        uLenMin   = 1;
        uLenMax   = 6;
        repeat (2000) tick();
        randomReq = 1'b0;
        repeat (200) tick();
        bus.req = '0;
        waitIdle(100, "drain");
        repeat (2) tick();

        $display("[TB] reset while the UART is sending");
        uDelayMin = 1;
        uDelayMax = 1;
        uLenMin   = 8;
        uLenMax   = 8;
        bus.req_byte[7:0] = 8'h77;
        bus.req           = 4'b0001;
        tick();
        repeat (3) tick();
        checkOutput("wd_busy", 32'(bus.busy), 32'd1);
        checkOutput("wd_is_transmitting", 32'(bus.is_transmitting), 32'd1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_transmit", 32'(bus.transmit), 32'd0);
        checkOutput("midrst_ack", 32'(bus.ack), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_tx_byte", 32'(bus.tx_byte), 32'd0);
        checkOutput("midrst_timeout_err", 32'(bus.timeout_err), 32'd0);
        bus.is_transmitting  = 1'b0;
        uState               = 0;
        bus.req_byte[31:24]  = 8'hC3;
        bus.req              = 4'b1000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postrst_ack", 32'(bus.ack), 32'(4'b1000));
        checkOutput("postrst_transmit", 32'(bus.transmit), 32'd1);
        checkOutput("postrst_tx_byte", 32'(bus.tx_byte), 32'(8'hC3));
        waitIdle(100, "final");
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
